// File: rtl/lsu.sv
// lsu: RV32I load/store unit that runs one req/ready data-memory access per request,
// builds lane enables and replicated store data, and sign/zero-extends load results.
module lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_in,
  input  logic        we_in,
  input  logic [2:0]  op_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        busy_out,
  output logic        done_out,
  output logic [31:0] rdata_out,
  output logic        misalign_out,
  output logic        fault_out,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [3:0]  mem_be_out,
  output logic [31:0] mem_wdata_out,
  input  logic        mem_ready_in,
  input  logic [31:0] mem_rdata_in
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [2:0]  r_op;
  logic [1:0]  r_a;
  logic        w_fault, w_mis;
  logic [3:0]  w_be;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic [31:0] w_wdata, w_load;
  always_comb begin
    w_fault = (op_in[1:0] == 2'b11) || (op_in == 3'b110) || (we_in && op_in[2]);
    w_mis = (op_in[1:0] == 2'b01 && addr_in[0]) || (op_in[1:0] == 2'b10 && addr_in[1:0] != 2'b00);
    w_be = op_in[1:0] == 2'b00 ? 4'b0001 << addr_in[1:0] :
           op_in[1:0] == 2'b01 ? (addr_in[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    w_wdata = !we_in ? 32'h0 :
              op_in[1:0] == 2'b00 ? {4{wdata_in[7:0]}} :
              op_in[1:0] == 2'b01 ? {2{wdata_in[15:0]}} : wdata_in;
    w_b = mem_rdata_in[{r_a, 3'b000} +: 8];
    w_h = mem_rdata_in[{r_a[1], 4'b0000} +: 16];
    // op[2] marks the unsigned variants, which suppress sign fill
    w_load = r_op[1:0] == 2'b00 ? {{24{~r_op[2] & w_b[7]}}, w_b} :
             r_op[1:0] == 2'b01 ? {{16{~r_op[2] & w_h[15]}}, w_h} : mem_rdata_in;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_op          <= '0;
      r_a           <= '0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      rdata_out     <= '0;
      misalign_out  <= 1'b0;
      fault_out     <= 1'b0;
      mem_req_out   <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_be_out    <= '0;
      mem_wdata_out <= '0;
    end else
      case (r_state)
        IDLE: if (start_in) begin
          r_op     <= op_in;
          r_a      <= addr_in[1:0];
          r_cnt    <= '0;
          busy_out <= 1'b1;
          if (w_fault || w_mis) begin
            r_state      <= DONE;
            done_out     <= 1'b1;
            fault_out    <= w_fault;
            misalign_out <= !w_fault && w_mis;
          end else begin
            r_state       <= REQ;
            mem_req_out   <= 1'b1;
            mem_we_out    <= we_in;
            mem_addr_out  <= {addr_in[31:2], 2'b00};
            mem_be_out    <= w_be;
            mem_wdata_out <= w_wdata;
          end
        end
        REQ: if (mem_ready_in || r_cnt == 8'(TIMEOUT - 1)) begin
          r_state     <= DONE;
          done_out    <= 1'b1;
          mem_req_out <= 1'b0;
          mem_we_out  <= 1'b0;
          fault_out   <= !mem_ready_in;
          if (mem_ready_in && !mem_we_out) rdata_out <= w_load;
        end else r_cnt <= r_cnt + 8'd1;
        default: begin
          r_state      <= IDLE;
          done_out     <= 1'b0;
          busy_out     <= 1'b0;
          fault_out    <= 1'b0;
          misalign_out <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed and randomized checks of lsu against a byte-level reference model.
module tb_lsu;
  localparam int TO = 4;
  logic        clk = 0, rst_n = 0, start_in = 0, we_in = 0, mem_ready_in = 0;
  logic [2:0]  op_in = 0;
  logic [31:0] addr_in = 0, wdata_in = 0, mem_rdata_in = 0;
  logic        busy_out, done_out, misalign_out, fault_out, mem_req_out, mem_we_out;
  logic [31:0] rdata_out, mem_addr_out, mem_wdata_out;
  logic [3:0]  mem_be_out;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] m_rdata = 0;
  int          o_done, o_reqc, o_bursts;
  logic        o_stable, o_we, o_mis, o_flt;
  logic [31:0] o_rd, o_addr, o_wd;
  logic [3:0]  o_be;
  logic [1:0]  o_post;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .we_in(we_in), .op_in(op_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .busy_out(busy_out), .done_out(done_out),
    .rdata_out(rdata_out), .misalign_out(misalign_out), .fault_out(fault_out),
    .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
    .mem_be_out(mem_be_out), .mem_wdata_out(mem_wdata_out), .mem_ready_in(mem_ready_in),
    .mem_rdata_in(mem_rdata_in)
  );

  function automatic int m_size(input logic [2:0] op);
    return op[1:0] == 2'b00 ? 1 : op[1:0] == 2'b01 ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] op, input logic [1:0] a);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (i >= int'(a)) && (i < int'(a) + m_size(op));
    return r;
  endfunction

  function automatic logic [31:0] m_wd(input logic we, input logic [2:0] op, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % m_size(op)) +: 8];
    return we ? r : 32'h0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [1:0] a, input logic [31:0] w);
    longint v = 0;
    int sz = m_size(op);
    for (int j = 0; j < sz; j++) v = v | (longint'(w[8*(int'(a)+j) +: 8]) << (8*j));
    if (!op[2] && sz < 4 && ((v >> (8*sz-1)) & 1) == 1) v = v - (longint'(1) << (8*sz));
    return v[31:0];
  endfunction

  // Issues one request starting at a negedge; ready is given in the (waits+1)-th req cycle.
  task automatic run(input logic we, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rw, input int waits, input int poke);
    logic prev = 0;
    we_in = we; op_in = op; addr_in = a; wdata_in = wd; start_in = 1;
    o_done = -1; o_reqc = 0; o_bursts = 0; o_stable = 1;
    o_addr = 0; o_be = 0; o_wd = 0; o_we = 0; o_rd = 0; o_mis = 0; o_flt = 0;
    @(posedge clk); #1 start_in = 0;
    for (int c = 1; c <= 20 && o_done < 0; c++) begin
      @(negedge clk);
      start_in = (c == poke);
      mem_ready_in = 0;
      mem_rdata_in = $urandom;
      if (mem_req_out) begin
        if (!prev) o_bursts++;
        if (o_reqc == 0) begin
          o_addr = mem_addr_out; o_be = mem_be_out; o_wd = mem_wdata_out; o_we = mem_we_out;
        end else if ({mem_addr_out, mem_be_out, mem_wdata_out, mem_we_out} !== {o_addr, o_be, o_wd, o_we})
          o_stable = 0;
        o_reqc++;
        if (o_reqc == waits + 1) begin mem_ready_in = 1; mem_rdata_in = rw; end
      end
      prev = mem_req_out;
      if (done_out) begin o_done = c; o_rd = rdata_out; o_mis = misalign_out; o_flt = fault_out; end
    end
    @(negedge clk);
    start_in = 0;
    o_post = {done_out, busy_out};
    if (mem_req_out && !prev) o_bursts++;
  endtask

  task automatic test_reset();
    #3;
    n_chk++;
    if ({busy_out, done_out, rdata_out, misalign_out, fault_out, mem_req_out, mem_we_out,
         mem_addr_out, mem_be_out, mem_wdata_out} !== '0) begin
      n_fail++; $display("FAIL reset: outputs not all zero (req=%b busy=%b rdata=%h)", mem_req_out, busy_out, rdata_out);
    end
    @(negedge clk); @(negedge clk); rst_n = 1; @(negedge clk);
  endtask

  task automatic test_lb_lbu();
    run(0, 3'b000, 32'h1003, 0, 32'h80FF_1234, 0, 0);
    n_chk += 4;
    if (o_addr !== 32'h1000) begin n_fail++; $display("FAIL lb_addr: got %h want 00001000", o_addr); end
    if (o_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b want 1000", o_be); end
    if (o_done !== 2) begin n_fail++; $display("FAIL lb_done_cycle: got %0d want 2", o_done); end
    if (o_rd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata: got %h want ffffff80", o_rd); end
    run(0, 3'b100, 32'h1003, 0, 32'h80FF_1234, 0, 0);
    n_chk += 2;
    if (o_rd !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_rdata: got %h want 00000080", o_rd); end
    if (o_post !== 2'b00) begin n_fail++; $display("FAIL lbu_post_done: done/busy=%b want 00", o_post); end
    m_rdata = 32'h80;
  endtask

  task automatic test_sh();
    run(1, 3'b001, 32'h2002, 32'hDEAD_BEEF, 32'h1111_1111, 0, 0);
    n_chk += 4;
    if (o_we !== 1'b1) begin n_fail++; $display("FAIL sh_we: got %b want 1", o_we); end
    if (o_be !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b want 1100", o_be); end
    if (o_wd !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL sh_wdata: got %h want beefbeef", o_wd); end
    if (o_rd !== m_rdata) begin n_fail++; $display("FAIL sh_rdata_kept: got %h want %h", o_rd, m_rdata); end
  endtask

  task automatic test_misalign_illegal();
    run(0, 3'b010, 32'h3001, 0, 0, 0, 0);
    n_chk += 3;
    if (o_reqc !== 0) begin n_fail++; $display("FAIL lw_mis_req: got %0d req cycles want 0", o_reqc); end
    if (o_done !== 1) begin n_fail++; $display("FAIL lw_mis_done: got cycle %0d want 1", o_done); end
    if ({o_mis, o_flt} !== 2'b10) begin n_fail++; $display("FAIL lw_mis_flags: mis/flt=%b%b want 10", o_mis, o_flt); end
    run(0, 3'b011, 32'h3000, 0, 0, 0, 0);
    n_chk += 2;
    if ({o_mis, o_flt} !== 2'b01) begin n_fail++; $display("FAIL illegal_flags: mis/flt=%b%b want 01", o_mis, o_flt); end
    if (o_rd !== m_rdata) begin n_fail++; $display("FAIL illegal_rdata_kept: got %h want %h", o_rd, m_rdata); end
  endtask

  task automatic test_waits_timeout();
    run(0, 3'b010, 32'h0000_0040, 0, 32'h1234_5678, 100, 0);
    n_chk += 4;
    if (o_reqc !== TO) begin n_fail++; $display("FAIL timeout_req_len: got %0d want %0d", o_reqc, TO); end
    if (o_done !== TO + 1) begin n_fail++; $display("FAIL timeout_done: got cycle %0d want %0d", o_done, TO + 1); end
    if (o_flt !== 1'b1) begin n_fail++; $display("FAIL timeout_fault: got %b want 1", o_flt); end
    if (o_rd !== m_rdata) begin n_fail++; $display("FAIL timeout_rdata_kept: got %h want %h", o_rd, m_rdata); end
    run(0, 3'b010, 32'h0000_0044, 0, 32'hCAFE_F00D, 3, 0);
    n_chk += 4;
    if (o_stable !== 1'b1) begin n_fail++; $display("FAIL wait_stable: bus fields changed during req"); end
    if (o_done !== 5) begin n_fail++; $display("FAIL wait_done: got cycle %0d want 5", o_done); end
    if (o_flt !== 1'b0) begin n_fail++; $display("FAIL wait_fault: got %b want 0", o_flt); end
    if (o_rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL wait_rdata: got %h want cafef00d", o_rd); end
    m_rdata = 32'hCAFE_F00D;
  endtask

  task automatic test_busy_ignore();
    int extra = 0;
    run(0, 3'b101, 32'h0000_0052, 0, 32'h8001_0000, 3, 2);
    for (int c = 0; c < 4; c++) begin @(negedge clk); extra += mem_req_out; end
    n_chk += 3;
    if (o_bursts + extra !== 1) begin n_fail++; $display("FAIL busy_bursts: got %0d want 1", o_bursts + extra); end
    if (o_done !== 5) begin n_fail++; $display("FAIL busy_done: got cycle %0d want 5", o_done); end
    if (o_rd !== 32'h0000_8001) begin n_fail++; $display("FAIL busy_lhu: got %h want 00008001", o_rd); end
    m_rdata = 32'h0000_8001;
  endtask

  task automatic test_reset_mid_req();
    int seen = 0;
    we_in = 0; op_in = 3'b010; addr_in = 32'h100; start_in = 1;
    @(posedge clk); #1 start_in = 0;
    @(negedge clk); @(negedge clk);
    n_chk++;
    if (mem_req_out !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: req=%b want 1", mem_req_out); end
    rst_n = 0; #1;
    n_chk++;
    if ({busy_out, done_out, rdata_out, fault_out, mem_req_out, mem_addr_out, mem_be_out} !== '0) begin
      n_fail++; $display("FAIL rst_mid_clear: req=%b busy=%b rdata=%h want zeros", mem_req_out, busy_out, rdata_out);
    end
    @(negedge clk); rst_n = 1;
    for (int c = 0; c < 8; c++) begin @(negedge clk); seen += done_out + mem_req_out; end
    n_chk++;
    if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_after: got %0d done/req cycles want 0", seen); end
    m_rdata = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic we = 1'($urandom);
      logic [2:0] op = 3'($urandom_range(0, 7));
      logic [31:0] a = $urandom, wd = $urandom, rw = $urandom;
      int waits = $urandom_range(0, 5);
      logic ill = !(op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) || (we && op[2]);
      logic mis = !ill && (int'(a[1:0]) % m_size(op) != 0);
      int e_done, e_reqc;
      logic e_flt;
      run(we, op, a, wd, rw, waits, 0);
      e_done = (ill || mis) ? 1 : waits < TO ? waits + 2 : TO + 1;
      e_reqc = (ill || mis) ? 0 : waits < TO ? waits + 1 : TO;
      e_flt = ill || (!mis && waits >= TO);
      if (!ill && !mis && waits < TO && !we) m_rdata = m_load(op, a[1:0], rw);
      n_chk += 4;
      if (o_done !== e_done) begin n_fail++; $display("FAIL rnd%0d_done: got %0d want %0d", n, o_done, e_done); end
      if (o_reqc !== e_reqc) begin n_fail++; $display("FAIL rnd%0d_reqlen: got %0d want %0d", n, o_reqc, e_reqc); end
      if ({o_mis, o_flt} !== {mis, e_flt}) begin n_fail++; $display("FAIL rnd%0d_flags: mis/flt=%b%b want %b%b", n, o_mis, o_flt, mis, e_flt); end
      if (o_rd !== m_rdata) begin n_fail++; $display("FAIL rnd%0d_rdata: got %h want %h", n, o_rd, m_rdata); end
      if (e_reqc > 0) begin
        n_chk++;
        if ({o_addr, o_be, o_wd, o_we, o_stable} !== {a[31:2], 2'b00, m_be(op, a[1:0]), m_wd(we, op, wd), we, 1'b1}) begin
          n_fail++; $display("FAIL rnd%0d_bus: addr=%h be=%b wd=%h we=%b stable=%b want %h %b %h %b 1", n, o_addr, o_be, o_wd, o_we,
                             o_stable, {a[31:2], 2'b00}, m_be(op, a[1:0]), m_wd(we, op, wd), we);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lb_lbu();
    test_sh();
    test_misalign_illegal();
    test_waits_timeout();
    test_busy_ignore();
    test_reset_mid_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
